multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
//  Moore/Mealy FSM sequencing a multicycle MIPS datapath (shared memory, IR, A/B, ALUOut regs) for
//  R-type(add/sub/and/or/slt), lw, sw, beq, bne, addi, andi, j, jal, jr. Drives all datapath muxes and
//  enables each cycle; stalls on a variable-latency memory via mem_ready.
// PARAMETERS
//  STATE_W  4  width of state register / debug state output
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26] (valid from DECODE onward)
//  func         in   6  IR[5:0]
//  zero         in   1  ALU zero flag (combinational, current cycle)
//  mem_ready    in   1  memory access complete this cycle
//  pc_write     out  1  PC load enable
//  ir_write     out  1  IR load enable
//  iord         out  1  mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1  memory read request (held until mem_ready)
//  mem_write    out  1  memory write request (held until mem_ready)
//  reg_write    out  1  register file write enable
//  reg_dst      out  1  write reg: 0=rt, 1=rd
//  wr_sel       out  1  1 forces write reg = 31 (jal)
//  wd_sel       out  1  1 selects PC (already PC+4) as write data (jal)
//  mem_to_reg   out  1  write data: 0=ALUOut, 1=MDR
//  alu_src_a    out  1  0=PC, 1=A
//  alu_src_b    out  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
//  alu_operation out 3  010 add,110 sub,000 and,001 or,111 slt,101 none
//  pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
//  illegal      out  1  one-cycle pulse on unsupported opcode/func
//  instr_done   out  1  one-cycle pulse in last cycle of every instruction
//  state        out  STATE_W  current state (debug)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH; every output 0 while rst_n low; reset mid-access aborts it.
//  - Outputs are decoded from state only, except gated enables noted (mem_ready, zero).
//  - Unlisted outputs are 0 in each state.
//  - FETCH(0): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, op=add, pc_src=00.
//    ir_write=pc_write=mem_ready. Stay until mem_ready, then go to DECODE.
//  - DECODE(1): alu_src_a=0, alu_src_b=11, op=add (ALUOut<=branch target). Next state by opcode:
//    000000 R_EXEC; 100011/101011 MEM_ADDR; 001000/001100 I_EXEC; 000100/000101 BRANCH;
//    000010 JUMP; 000011 JAL; 111111 JR; other: illegal=1, instr_done=1, go to FETCH.
//  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, add. lw goes to MEM_RD, sw to MEM_WR.
//  - MEM_RD(3): mem_read=1, iord=1; wait mem_ready, then go to MEM_WB.
//  - MEM_WB(4): reg_write=1, reg_dst=0, mem_to_reg=1; instr_done; go to FETCH.
//  - MEM_WR(5): mem_write=1, iord=1; on mem_ready: instr_done, go to FETCH.
//  - R_EXEC(6): alu_src_a=1, alu_src_b=00, op from func:
//    100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, else 101.
//  - R_WB(7): reg_dst=1, mem_to_reg=0, reg_write=1 if func legal.
//    Illegal func: reg_write=0, illegal=1. instr_done; go to FETCH.
//  - I_EXEC(8): alu_src_a=1, alu_src_b=10, op add (addi) / and (andi).
//  - I_WB(9): reg_write=1, reg_dst=0, mem_to_reg=0; instr_done; go to FETCH.
//  - BRANCH(10): alu_src_a=1, alu_src_b=00, sub, pc_src=01.
//    pc_write=zero (beq) or ~zero (bne). instr_done; go to FETCH.
//  - JUMP(11): pc_src=10, pc_write=1; instr_done; go to FETCH.
//  - JAL(12): wr_sel=1, wd_sel=1, reg_write=1, pc_src=10, pc_write=1; instr_done; go to FETCH.
//  - JR(13): pc_src=11, pc_write=1; instr_done; go to FETCH.
//  - Latency with mem_ready=1 always:
//    R/addi/andi/sw = 4 cycles; lw = 5; beq/bne/j/jal/jr = 3.
//    Each mem_ready-low cycle adds one cycle.
//  - mem_read/mem_write stay asserted and stable (iord fixed) while waiting.
//    mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
//  - States 14-15 are unreachable; if entered, go to FETCH with all outputs 0.
// STRUCTURE
//  - Package mips_ctrl_pkg: opcode/func localparams, ALU operation codes, alu_src_b/pc_src encodings,
//    state encodings.
//  - Sub-module alu_control (comb): inputs alu_op class + func; outputs alu_operation and func_legal.
//    Used in R_EXEC/R_WB.
//  - FSM body: one state register (async clear) and one combinational next-state/output block.
// TESTING
//  - Reset: rst_n=0 mid-MEM_RD -> all outputs 0, state=0.
//    After release: mem_read=1, iord=0 next cycle.
//  - add (op 000000, func 100000), mem_ready=1 -> states 0,1,6,7.
//    alu_operation=010 in 6; reg_write=1, reg_dst=1 in 7; instr_done in 7.
//  - lw with mem_ready low 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4.
//    mem_read stays 1, iord stays 1 in state 3; mem_to_reg=1 in 4.
//  - beq with zero=1 -> pc_write=1, pc_src=01 in state 10.
//    bne with zero=1 -> pc_write=0. Both take 3 cycles.
//  - jal -> state 12: wr_sel=1, wd_sel=1, reg_write=1, pc_src=10.
//    jr (111111) -> state 13: pc_src=11.
//  - opcode 111000 -> illegal=1 in DECODE, then back to FETCH.
//    func 000000 R-type -> illegal=1, reg_write=0 in R_WB.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funcs, ALU codes,
// datapath mux selects, FSM states and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  localparam logic [2:0] ALU_NONE = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  // ACLS_FUNC lets the R-type func field pick the ALU operation.
  typedef enum logic [1:0] {
    ACLS_ADD  = 2'd0,
    ACLS_SUB  = 2'd1,
    ACLS_AND  = 2'd2,
    ACLS_FUNC = 2'd3
  } alu_cls_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       wr_sel;
    logic       wd_sel;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_operation;
    logic [1:0] pc_src;
    logic       illegal;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/alu_control.sv
// Maps an ALU operation class (and the R-type func field) to the 3-bit ALU code,
// and flags whether func names a supported R-type operation.
module alu_control
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e   alu_cls_i,
  input  logic [5:0] func_i,
  output logic [2:0] alu_operation_o,
  output logic       func_legal_o
);

  logic [2:0] func_op;

  always_comb begin
    func_op      = ALU_NONE;
    func_legal_o = 1'b1;
    case (func_i)
      FN_ADD:  func_op = ALU_ADD;
      FN_SUB:  func_op = ALU_SUB;
      FN_AND:  func_op = ALU_AND;
      FN_OR:   func_op = ALU_OR;
      FN_SLT:  func_op = ALU_SLT;
      default: begin
        func_op      = ALU_NONE;
        func_legal_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    alu_operation_o = ALU_NONE;
    case (alu_cls_i)
      ACLS_ADD:  alu_operation_o = ALU_ADD;
      ACLS_SUB:  alu_operation_o = ALU_SUB;
      ACLS_AND:  alu_operation_o = ALU_AND;
      ACLS_FUNC: alu_operation_o = func_op;
      default:   alu_operation_o = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// stalls on mem_ready. All outputs are forced low while rst_n is asserted.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               wr_sel,
  output logic               wd_sel,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_operation,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  alu_cls_e   alu_cls;
  logic [2:0] alu_op_w;
  logic       func_legal_w;
  ctrl_t      ctrl, ctrl_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // The IR is stable from DECODE onward, so opcode can steer later states.
  always_comb begin
    alu_cls = ACLS_ADD;
    case (state_q)
      S_R_EXEC, S_R_WB: alu_cls = ACLS_FUNC;
      S_BRANCH:         alu_cls = ACLS_SUB;
      S_I_EXEC:         alu_cls = (opcode == OP_ANDI) ? ACLS_AND : ACLS_ADD;
      default:          alu_cls = ACLS_ADD;
    endcase
  end

  alu_control u_alu_control (
    .alu_cls_i      (alu_cls),
    .func_i         (func),
    .alu_operation_o(alu_op_w),
    .func_legal_o   (func_legal_w)
  );

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read      = 1'b1;
        ctrl.alu_src_b     = SRCB_FOUR;
        ctrl.alu_operation = ALU_ADD;
        ctrl.pc_src        = PC_ALU;
        ctrl.ir_write      = mem_ready;
        ctrl.pc_write      = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b     = SRCB_IMM_SH;
        ctrl.alu_operation = ALU_ADD;
        case (opcode)
          OP_RTYPE:         state_d = S_R_EXEC;
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_JR:            state_d = S_JR;
          default: begin
            ctrl.illegal    = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_operation = ALU_ADD;
        state_d            = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_operation = alu_op_w;
        state_d            = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = func_legal_w;
        ctrl.illegal    = ~func_legal_w;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_operation = alu_op_w;
        state_d            = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_operation = alu_op_w;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.pc_write      = (opcode == OP_BEQ) ? zero : ~zero;
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src     = PC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JAL: begin
        ctrl.wr_sel     = 1'b1;
        ctrl.wd_sel     = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JR: begin
        ctrl.pc_src     = PC_REG;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctrl_out      = rst_n ? ctrl : '0;
  assign pc_write      = ctrl_out.pc_write;
  assign ir_write      = ctrl_out.ir_write;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign reg_write     = ctrl_out.reg_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign wr_sel        = ctrl_out.wr_sel;
  assign wd_sel        = ctrl_out.wd_sel;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_operation = ctrl_out.alu_operation;
  assign pc_src        = ctrl_out.pc_src;
  assign illegal       = ctrl_out.illegal;
  assign instr_done    = ctrl_out.instr_done;
  assign state         = rst_n ? STATE_W'(state_q) : '0;

endmodule
